// File: rtl/ddr_rd_pkg.sv
// Shared types and AXI constants for the DDR frame read controller.
package ddr_rd_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ADDR,
    S_DATA,
    S_SETTLE
  } state_e;

  localparam logic [2:0] ARSIZE_32B   = 3'b101;
  localparam logic [1:0] ARBURST_INCR = 2'b01;
  localparam logic [1:0] RRESP_OKAY   = 2'b00;

endpackage

// File: rtl/ddr_rd_burst_ctrl.sv
// AXI4 read master fetching a frame from DDR in fixed bursts into a FIFO.
module ddr_rd_burst_ctrl
  import ddr_rd_pkg::*;
#(
  parameter int ADDR_WIDTH  = 28,
  parameter int DATA_WIDTH  = 256,
  parameter int BURST_LEN   = 16,
  parameter int FRAME_BEATS = 115200,
  parameter int FIFO_DEPTH  = 512,
  parameter int LEVEL_WIDTH = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   frame_start,
  input  logic [ADDR_WIDTH-1:0]  frame_base,
  output logic                   m_arvalid,
  input  logic                   m_arready,
  output logic [ADDR_WIDTH-1:0]  m_araddr,
  output logic [7:0]             m_arlen,
  output logic [2:0]             m_arsize,
  output logic [1:0]             m_arburst,
  input  logic                   m_rvalid,
  output logic                   m_rready,
  input  logic [DATA_WIDTH-1:0]  m_rdata,
  input  logic                   m_rlast,
  input  logic [1:0]             m_rresp,
  output logic                   fifo_wr_en,
  output logic [DATA_WIDTH-1:0]  fifo_wr_data,
  input  logic [LEVEL_WIDTH-1:0] fifo_wr_water_level,
  input  logic                   fifo_wr_full,
  output logic                   busy,
  output logic                   rd_err
);

  localparam int CW = $clog2(FRAME_BEATS + 1);
  localparam int BW = $clog2(BURST_LEN) + 1;

  localparam logic [CW-1:0] FRAME_CNT = CW'(FRAME_BEATS);
  localparam logic [CW-1:0] BURST_CNT = CW'(BURST_LEN);
  localparam logic [BW-1:0] BLEN      = BW'(BURST_LEN);
  localparam logic [BW-1:0] BLEN_M1   = BW'(BURST_LEN - 1);
  localparam logic [LEVEL_WIDTH-1:0] LVL_MAX =
    LEVEL_WIDTH'(FIFO_DEPTH - BURST_LEN);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(511);

  state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] pend_base_q, pend_base_d;
  logic                  pend_q, pend_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [BW-1:0]         bb_q, bb_d;
  logic                  wr_en_q, wr_en_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  err_q, err_d;

  logic [ADDR_WIDTH-1:0] start_base;
  logic [CW-1:0]         cnt_inc;
  logic                  beat;
  logic                  in_burst;
  logic                  err_set;
  logic                  hold_restart;

  assign start_base = frame_base & ALIGN_MASK;
  assign cnt_inc    = cnt_q + BURST_CNT;
  assign beat       = m_rvalid && (state_q == S_DATA);
  assign in_burst   = bb_q < BLEN;

  assign hold_restart = frame_start &&
    ((state_q == S_ADDR) || (state_q == S_DATA));

  // bb_q counts beats already taken in this burst
  assign err_set =
    (beat && (m_rresp != RRESP_OKAY)) ||
    (beat && m_rlast && (bb_q < BLEN_M1)) ||
    (beat && !m_rlast && (bb_q == BLEN_M1)) ||
    (wr_en_q && fifo_wr_full);

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    pend_d      = pend_q;
    pend_base_d = pend_base_q;
    cnt_d       = cnt_q;
    bb_d        = bb_q;
    wr_en_d     = beat && in_burst;
    wr_data_d   = beat ? m_rdata : wr_data_q;
    err_d       = (err_q && !frame_start) || err_set;

    if (hold_restart) begin
      pend_d      = 1'b1;
      pend_base_d = start_base;
    end

    unique case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          base_d  = start_base;
          cnt_d   = '0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (frame_start) begin
          base_d = start_base;
          cnt_d  = '0;
        end else if (fifo_wr_water_level <= LVL_MAX) begin
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (m_arready) begin
          bb_d    = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (beat) begin
          if (in_burst) bb_d = bb_q + BW'(1);
          if (m_rlast) state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        pend_d = 1'b0;
        if (frame_start || pend_q) begin
          base_d  = frame_start ? start_base : pend_base_q;
          cnt_d   = '0;
          state_d = S_CHECK;
        end else begin
          cnt_d   = cnt_inc;
          state_d = (cnt_inc == FRAME_CNT) ? S_IDLE : S_CHECK;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      pend_base_q <= '0;
      pend_q      <= 1'b0;
      cnt_q       <= '0;
      bb_q        <= '0;
      wr_en_q     <= 1'b0;
      wr_data_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      pend_base_q <= pend_base_d;
      pend_q      <= pend_d;
      cnt_q       <= cnt_d;
      bb_q        <= bb_d;
      wr_en_q     <= wr_en_d;
      wr_data_q   <= wr_data_d;
      err_q       <= err_d;
    end
  end

  assign m_arvalid    = (state_q == S_ADDR);
  assign m_araddr     = base_q + (ADDR_WIDTH'(cnt_q) << 5);
  assign m_arlen      = 8'(BURST_LEN - 1);
  assign m_arsize     = ARSIZE_32B;
  assign m_arburst    = ARBURST_INCR;
  assign m_rready     = (state_q == S_DATA);
  assign fifo_wr_en   = wr_en_q;
  assign fifo_wr_data = wr_data_q;
  assign busy         = (state_q != S_IDLE);
  assign rd_err       = err_q;

endmodule
